// File: rtl/sram_rr_arbiter_pkg.sv
// Shared constants, FSM state, in-flight tag and strobe expansion for the
// two-port round-robin SRAM sequencer.
package sram_arb_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 128;
  localparam int STRB_W = 16;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic id;
    logic write;
  } tag_t;

  // Byte strobe i covers data bits 8i+7:8i; a set strobe yields ones in the mask.
  function automatic logic [DATA_W-1:0] strb_to_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] mask;
    for (int i = 0; i < STRB_W; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// One requester's request/response channel; the arbiter takes two of these
// as slave modports.
interface sram_arb_if #(
  parameter int ADDR_W = sram_arb_pkg::ADDR_W,
  parameter int DATA_W = sram_arb_pkg::DATA_W,
  parameter int STRB_W = sram_arb_pkg::STRB_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              rsp_valid;
  logic              rsp_write;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_write
  );

endinterface

// File: rtl/sram_rr_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer names the port that wins a tie
// and moves to the other port after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (&valid) begin
        grant = ptr ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter and sequencer for a single-port byte-writable SRAM
// macro with a one-cycle registered read; zero-fills the array after reset.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DEPTH     = sram_arb_pkg::DEPTH,
  parameter int ADDR_W    = sram_arb_pkg::ADDR_W,
  parameter int DATA_W    = sram_arb_pkg::DATA_W,
  parameter int STRB_W    = sram_arb_pkg::STRB_W,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  sram_arb_if.slave         p0,
  sram_arb_if.slave         p1,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [DATA_W-1:0] sram_bwen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  tag_t              tag0;
  tag_t              tag1;
  logic              run;
  logic [1:0]        valid;
  logic [1:0]        grant;
  logic              any_grant;
  logic              gnt_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  assign run   = (state == RUN);
  assign busy  = (state == INIT);
  assign valid = {p1.req_valid, p0.req_valid};

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst   (RST),
    .en    (run),
    .valid (valid),
    .grant (grant)
  );

  assign p0.req_ready = grant[0];
  assign p1.req_ready = grant[1];
  assign any_grant    = |grant;
  assign gnt_id       = grant[1];
  assign sel_write    = gnt_id ? p1.req_write : p0.req_write;
  assign sel_addr     = gnt_id ? p1.req_addr  : p0.req_addr;
  assign sel_wdata    = gnt_id ? p1.req_wdata : p0.req_wdata;
  assign sel_wstrb    = gnt_id ? p1.req_wstrb : p0.req_wstrb;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= INIT_ZERO ? INIT : RUN;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == ADDR_W'(DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  // Macro pins are registered; on reads and idle cycles the data bus holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_bwen <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
    end else if (state == INIT) begin
      sram_cen  <= 1'b0;
      sram_wen  <= 1'b0;
      sram_bwen <= '0;
      sram_a    <= init_cnt;
      sram_d    <= '0;
    end else if (any_grant) begin
      sram_cen <= 1'b0;
      sram_wen <= ~sel_write;
      sram_a   <= sel_addr;
      if (sel_write) begin
        sram_d    <= sel_wdata;
        sram_bwen <= ~strb_to_mask(sel_wstrb);
      end else begin
        sram_bwen <= '1;
      end
    end else begin
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_bwen <= '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag0 <= '0;
      tag1 <= '0;
    end else begin
      tag0 <= '{valid: any_grant, id: gnt_id, write: sel_write};
      tag1 <= tag0;
    end
  end

  // Q is only defined in the cycle after a macro read, which is when tag1 holds it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p0.rsp_valid <= 1'b0;
      p1.rsp_valid <= 1'b0;
      p0.rsp_write <= 1'b0;
      p1.rsp_write <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      p0.rsp_valid <= tag1.valid & ~tag1.id;
      p1.rsp_valid <= tag1.valid &  tag1.id;
      p0.rsp_write <= tag1.write;
      p1.rsp_write <= tag1.write;
      if (tag1.valid && !tag1.write) begin
        rsp_rdata <= sram_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Scoreboard bench for sram_rr_arbiter: directed requests push expected
// responses, a negedge monitor pops and compares them against a macro model.
module tb_sram_rr_arbiter;
  import sram_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] rsp_rdata;
  logic         busy;
  logic         sram_cen;
  logic         sram_wen;
  logic [127:0] sram_bwen;
  logic [5:0]   sram_a;
  logic [127:0] sram_d;
  logic [127:0] sram_q;

  sram_arb_if if0 ();
  sram_arb_if if1 ();

  always #5 clk = ~clk;

  sram_rr_arbiter dut (
    .CLK       (clk),
    .RST       (rst),
    .p0        (if0),
    .p1        (if1),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_bwen (sram_bwen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // Macro model: Q is garbage except in the cycle after a read.
  logic [127:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    sram_q = '0;
  end
  always @(posedge clk) begin
    if (!sram_cen && sram_wen) begin
      sram_q <= mem[sram_a];
    end else begin
      sram_q <= {$urandom, $urandom, $urandom, $urandom};
    end
    if (!sram_cen && !sram_wen) begin
      mem[sram_a] <= (mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
    end
  end

  typedef struct {
    int           port;
    bit           write;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [127:0] last_rd = '0;

  localparam logic [127:0] DATA5 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] ONES  = {128{1'b1}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] dpat(input int j, input logic [31:0] base);
    logic [31:0] w;
    w = base + 32'(j);
    return {4{w}};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (if0.rsp_valid || if1.rsp_valid) begin
      check_output("rsp_one_hot", {127'b0, if0.rsp_valid & if1.rsp_valid}, '0);
      if (sb.size() == 0) begin
        check_output("rsp_unexpected", 128'd1, 128'd0);
      end else begin
        e = sb.pop_front();
        check_output("rsp_port", {127'b0, if1.rsp_valid}, 128'(e.port));
        check_output("rsp_write", {127'b0, if1.rsp_valid ? if1.rsp_write : if0.rsp_write},
                     {127'b0, e.write});
        check_output("rsp_latency", 128'(cyc), 128'(e.due));
        if (!e.write) begin
          check_output("rsp_rdata", rsp_rdata, e.data);
          last_rd = e.data;
        end else begin
          check_output("rdata_hold", rsp_rdata, last_rd);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      check_output("rsp_missing", 128'd0, 128'd1);
      void'(sb.pop_front());
    end
  end

  // Drive one cycle of requests at a negedge; push whatever the bench expects granted.
  task automatic apply_stimulus(
    input bit v0, input bit w0, input int a0, input logic [127:0] d0, input logic [15:0] s0,
    input bit v1, input bit w1, input int a1, input logic [127:0] d1, input logic [15:0] s1,
    input bit er0, input bit er1, input logic [127:0] exp_rd);
    exp_t e;
    if0.req_valid = v0; if0.req_write = w0; if0.req_addr = 6'(a0);
    if0.req_wdata = d0; if0.req_wstrb = s0;
    if1.req_valid = v1; if1.req_write = w1; if1.req_addr = 6'(a1);
    if1.req_wdata = d1; if1.req_wstrb = s1;
    #1;
    check_output("req_ready_0", {127'b0, if0.req_ready}, {127'b0, er0});
    check_output("req_ready_1", {127'b0, if1.req_ready}, {127'b0, er1});
    if (er0 || er1) begin
      e.port  = er0 ? 0 : 1;
      e.write = er0 ? w0 : w1;
      e.data  = exp_rd;
      e.due   = cyc + 3;
      sb.push_back(e);
    end
    @(negedge clk);
    if0.req_valid = 1'b0;
    if1.req_valid = 1'b0;
  endtask

  task automatic p0_only(input bit w, input int a, input logic [127:0] d, input logic [15:0] s,
                         input logic [127:0] exp_rd);
    apply_stimulus(1'b1, w, a, d, s, 1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b0, exp_rd);
  endtask

  task automatic p1_only(input bit w, input int a, input logic [127:0] d, input logic [15:0] s,
                         input logic [127:0] exp_rd);
    apply_stimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, w, a, d, s, 1'b0, 1'b1, exp_rd);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 1'b0, 0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sb.delete();
    last_rd = '0;
    if0.req_valid = 1'b1;
    if1.req_valid = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check_output("rst_busy", {127'b0, busy}, 128'd1);
      check_output("rst_ready", {126'b0, if1.req_ready, if0.req_ready}, 128'd0);
      check_output("rst_rsp_valid", {126'b0, if1.rsp_valid, if0.rsp_valid}, 128'd0);
      check_output("rst_cen_wen", {126'b0, sram_cen, sram_wen}, 128'd3);
      check_output("rst_bwen", sram_bwen, ONES);
      check_output("rst_addr", {122'b0, sram_a}, 128'd0);
    end
  endtask

  // Release reset and watch the zero-fill walk; stop_k < 64 returns early for an abort.
  task automatic init_check(input int stop_k);
    rst = 1'b0;
    if0.req_valid = 1'b1;
    if1.req_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      check_output("init_busy", {127'b0, busy}, 128'd1);
      check_output("init_ready", {126'b0, if1.req_ready, if0.req_ready}, 128'd0);
      if (k == 0) begin
        check_output("init_first_idle", {127'b0, sram_cen}, 128'd1);
      end else begin
        check_output("init_addr", {122'b0, sram_a}, 128'(k - 1));
        check_output("init_pins", {126'b0, sram_cen, sram_wen}, 128'd0);
        check_output("init_bwen", sram_bwen, '0);
        check_output("init_d", sram_d, '0);
      end
      if (k == stop_k) return;
      @(negedge clk);
    end
    if0.req_valid = 1'b0;
    if1.req_valid = 1'b0;
    check_output("init_done_busy", {127'b0, busy}, 128'd0);
    check_output("init_last_addr", {122'b0, sram_a}, 128'd63);
  endtask

  initial begin
    rst = 1'b1;
    if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = '0;
    if0.req_wdata = '0;   if0.req_wstrb = '0;
    if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_addr = '0;
    if1.req_wdata = '0;   if1.req_wstrb = '0;
    $display("[TB] start");

    do_reset(3);
    init_check(64);
    for (int i = 0; i < 64; i++) p0_only(1'b0, i, '0, '0, '0);

    // Full write then back-to-back read of the same word.
    p0_only(1'b1, 5, DATA5, 16'hFFFF, '0);
    p0_only(1'b0, 5, '0, '0, DATA5);

    // Byte-0 partial write over all-ones, then a zero-strobe write that must not alter addr 5.
    p0_only(1'b1, 7, ONES, 16'hFFFF, '0);
    p0_only(1'b1, 7, 128'hAA, 16'h0001, '0);
    p0_only(1'b0, 7, '0, '0, {{120{1'b1}}, 8'hAA});
    p0_only(1'b1, 5, '0, 16'h0000, '0);
    p0_only(1'b0, 5, '0, '0, DATA5);
    idle();
    check_output("idle_cen", {127'b0, sram_cen}, 128'd1);
    repeat (4) idle();

    // Read in flight when reset hits: its response must never appear.
    p1_only(1'b0, 5, '0, '0, DATA5);
    do_reset(1);
    init_check(31);
    check_output("abort_addr30", {122'b0, sram_a}, 128'd30);
    do_reset(1);
    init_check(64);

    // Both ports valid for 8 cycles starting from pointer 0: grants alternate 0,1,...
    for (int i = 0; i < 8; i++) begin
      int j;
      j = i / 2;
      if (i % 2 == 0) begin
        apply_stimulus(1'b1, 1'b1, 20 + j, dpat(j, 32'hC0DE0000), 16'hFFFF,
                       1'b1, 1'b0, 20 + j, '0, '0, 1'b1, 1'b0, '0);
      end else begin
        apply_stimulus(1'b1, 1'b1, 21 + j, dpat(j + 1, 32'hC0DE0000), 16'hFFFF,
                       1'b1, 1'b0, 20 + j, '0, '0, 1'b0, 1'b1, dpat(j, 32'hC0DE0000));
      end
    end

    // Port 1 alone every cycle, then a tie goes to port 0 first.
    for (int i = 0; i < 4; i++) p1_only(1'b1, 30 + i, dpat(i, 32'hBEEF0000), 16'hFFFF, '0);
    apply_stimulus(1'b1, 1'b0, 30, '0, '0, 1'b1, 1'b0, 33, '0, '0, 1'b1, 1'b0,
                   dpat(0, 32'hBEEF0000));
    p1_only(1'b0, 33, '0, '0, dpat(3, 32'hBEEF0000));

    repeat (6) idle();
    check_output("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Two-requester, round-robin arbiter and sequencer for the 64×128 single-port byte-writable SRAM macro (active-low CEN/WEN/BWEN, one-cycle registered read). It sits between two masters (e.g. fetch and load/store refill) and the macro.
- It zero-fills the array after reset.
- It accepts at most one request per cycle and drives the macro pins from registers.
- It returns in-order responses, capturing the macro's Q only in the one cycle it is defined.

## Interface
Parameters:
- DEPTH, 64, words in the macro
- ADDR_W, 6, address width (log2 DEPTH)
- DATA_W, 128, word width
- STRB_W, 16, byte strobes (DATA_W/8)
- INIT_ZERO, 1, 1 = zero-fill the array after reset; 0 = skip

Ports (x = 0,1 for each requester):
- CLK  in  1  single clock; all logic is rising-edge
- RST  in  1  synchronous, active-high reset
- req_valid_x  in  1  request present
- req_ready_x  out  1  request accepted this cycle
- req_write_x  in  1  1 = write, 0 = read
- req_addr_x  in  ADDR_W  word address
- req_wdata_x  in  DATA_W  write data
- req_wstrb_x  in  STRB_W  byte enables, bit i covers bits 8i+7:8i
- rsp_valid_x  out  1  one-cycle response pulse; no backpressure
- rsp_write_x  out  1  response is a write acknowledge
- rsp_rdata  out  DATA_W  read data, shared; meaningful only with a read rsp_valid_x
- busy  out  1  high during INIT
- sram_cen, sram_wen  out  1  to macro, active low
- sram_bwen  out  DATA_W  to macro, active low per bit
- sram_a  out  ADDR_W  to macro
- sram_d  out  DATA_W  to macro
- sram_q  in  DATA_W  from macro

## Operation
- FSM has two states.
  - INIT: counter walks 0..DEPTH-1 and issues a write per cycle with CEN=0, WEN=0, BWEN=0, D=0. After the DEPTH-1 write it moves to RUN.
  - RUN: normal service. Entered on the cycle after reset when INIT_ZERO=0.
- Reset values: state INIT (or RUN when INIT_ZERO=0), counter 0, rr pointer 0, req_ready_x 0, rsp_valid_x 0.
  - Macro pin registers reset to idle: cen=1, wen=1, bwen=all-ones, a=0, d=0.
  - busy is 1 (or 0 when INIT_ZERO=0).
- Arbitration (RUN only; req_ready_x is combinational):
  - Only one valid: grant that one; pointer <= other index.
  - Both valid: grant port == pointer; pointer <= other index.
  - None valid: pointer holds.
- Grant registers the macro pins:
  - cen=0, wen=~req_write, a=req_addr.
  - Write: d=req_wdata; bwen bit j = ~wstrb[j/8].
  - Read: bwen all-ones, d don't-care (hold previous).
  - Idle cycle: cen=1, wen=1, bwen=all-ones; a and d hold.
- A write with wstrb=0 is still issued and acknowledged; the array is unchanged.
- A 2-deep shift of {valid, port id, write} tracks each access. At response time, rsp_valid_x pulses for the owning port; rsp_write_x copies the write bit.
- rsp_rdata is registered from sram_q in the cycle Q is valid and holds until the next read response. Garbage Q on non-read cycles never reaches rsp_rdata.
- RST asserted mid-INIT or mid-RUN aborts everything:
  - In-flight responses are dropped and the pins return to idle on the next edge.
  - INIT restarts from address 0.

## Timing
- Request handshake at edge E0. Macro access at E1. Response registered at E2; rsp_valid_x/rsp_rdata are visible in the cycle after E2. Latency is 3 edges for reads and writes alike.
- Throughput is one access per cycle, back-to-back, alternating or same port. Responses keep acceptance order.
- Read-after-write to the same address on consecutive grants returns the new data; the macro write at E1 precedes the read at E2.
- INIT with INIT_ZERO=1 lasts exactly DEPTH cycles after RST deasserts. req_ready_x first rises in cycle DEPTH, and busy falls in that same cycle.

## Structure
- Shared package `sram_arb_pkg` holds:
  - DEPTH/ADDR_W/DATA_W/STRB_W constants;
  - the FSM state enum {INIT, RUN};
  - the in-flight tag struct {valid, id, write}.
- One natural sub-module: `rr_arb2`, the 2-input round-robin grant with its pointer register.
- Strobe-to-bit-mask expansion is a function in the package.

## Test plan
- Reset, INIT_ZERO=1: busy high for 64 cycles with addresses 0..63 on sram_a and cen=0/wen=0/bwen=0/d=0; then read all 64 words -> every rdata = 0.
- Port 0 writes addr 5 = 0x0123…CDEF with wstrb=0xFFFF, then reads addr 5 -> read rsp_valid_0 3 edges after its handshake with rdata = the written value.
- Partial write: wstrb=0x0001 with data 0xAA to addr 7 (previously all-ones) -> readback 0xFF…FFAA.
- Both ports valid continuously for 8 cycles, pointer 0 after reset -> grants alternate 0,1,0,1…; responses alternate in the same order; no cycle is lost.
- Port 1 alone valid for 4 cycles -> granted every cycle, and the pointer lands on 0. Then both valid -> port 0 granted first.
- RST pulsed for one cycle while a read is in flight and during INIT word 30 -> no rsp_valid for the dropped read; INIT restarts at address 0 and completes in 64 cycles.
